// File: rtl/i2s_frame_uart_tx.sv
// I2S stereo word to UART 8N1 framer: sync byte + 8 data bytes per captured word.
// Ports: MCLK/RST (sync, active-high), data_trans/data_valid in, TXD/tx_busy/frame_drop out.
module i2s_frame_uart_tx #(
   parameter int         CLK_DIV   = 107,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         FIFO_AW   = 2,
   parameter int         DECIM     = 1
) (
   input  logic        MCLK,
   input  logic        RST,
   input  logic [63:0] data_trans,
   input  logic        data_valid,
   output logic        TXD,
   output logic        tx_busy,
   output logic [7:0]  frame_drop
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
   localparam logic [7:0]  DEC_LAST = 8'(DECIM - 1);

   state_t              r_state;
   logic                r_v1, r_v2, r_v3;
   logic [7:0]          r_dec;
   logic [63:0]         r_mem [2**FIFO_AW];
   logic [FIFO_AW:0]    r_wp, r_rp;
   logic [63:0]         r_shadow;
   logic [7:0]          r_sh;
   logic [3:0]          r_idx;
   logic [2:0]          r_bit;
   logic [15:0]         r_cnt;
   logic                r_txd;
   logic                r_busy;
   logic [7:0]          r_drop;

   logic w_cap, w_offer, w_empty, w_full, w_pop, w_push, w_last;

   // Capture on the falling edge of the synchronized strobe; data is settled by then.
   assign w_cap   = r_v3 & ~r_v2;
   assign w_offer = w_cap & (r_dec == 8'd0);
   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) &&
                    (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
   assign w_pop   = (r_state == S_LOAD);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push  = w_offer & (~w_full | w_pop);
   assign w_last  = (r_cnt == BIT_LAST);

   assign TXD        = r_txd;
   assign tx_busy    = r_busy;
   assign frame_drop = r_drop;

   always_ff @(posedge MCLK) begin
      if (RST) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_dec <= 8'd0;
      end else begin
         r_v1 <= data_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (w_cap)
            r_dec <= (r_dec == DEC_LAST) ? 8'd0 : r_dec + 8'd1;
      end
   end

   always_ff @(posedge MCLK) begin
      if (w_push)
         r_mem[r_wp[FIFO_AW-1:0]] <= data_trans;
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         r_wp   <= '0;
         r_drop <= 8'd0;
      end else begin
         if (w_push)
            r_wp <= r_wp + 1'b1;
         if (w_offer && w_full && !w_pop && r_drop != 8'hFF)
            r_drop <= r_drop + 8'd1;
      end
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_rp     <= '0;
         r_shadow <= 64'd0;
         r_sh     <= 8'd0;
         r_idx    <= 4'd0;
         r_bit    <= 3'd0;
         r_cnt    <= 16'd0;
         r_txd    <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_busy <= (r_state != S_IDLE) | ~w_empty;
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               if (!w_empty)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_shadow <= r_mem[r_rp[FIFO_AW-1:0]];
               r_rp     <= r_rp + 1'b1;
               r_sh     <= SYNC_BYTE;
               r_idx    <= 4'd0;
               r_bit    <= 3'd0;
               r_cnt    <= 16'd0;
               r_txd    <= 1'b0;
               r_state  <= S_START;
            end
            S_START: begin
               if (w_last) begin
                  r_cnt   <= 16'd0;
                  r_bit   <= 3'd0;
                  r_txd   <= r_sh[0];
                  r_sh    <= {1'b0, r_sh[7:1]};
                  r_state <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_last) begin
                  r_cnt <= 16'd0;
                  if (r_bit == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_txd <= r_sh[0];
                     r_sh  <= {1'b0, r_sh[7:1]};
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (w_last) begin
                  r_cnt <= 16'd0;
                  if (r_idx == 4'd8) begin
                     r_state <= S_IDLE;
                  end else begin
                     // Next data byte comes off the top of the shadow word.
                     r_idx    <= r_idx + 4'd1;
                     r_sh     <= r_shadow[63:56];
                     r_shadow <= {r_shadow[55:0], 8'd0};
                     r_txd    <= 1'b0;
                     r_state  <= S_START;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_frame_uart_tx.sv
// Directed bench for i2s_frame_uart_tx: UART frame decode, queueing, drops,
// decimation, mid-frame reset and drop-counter saturation.
module tb_i2s_frame_uart_tx;

   logic        mclk = 1'b0;
   logic        rst  = 1'b1;
   logic [63:0] data_trans = 64'd0;
   logic        data_valid = 1'b0;
   logic        txd1, busy1, txd2, busy2;
   logic [7:0]  drop1, drop2;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   i2s_frame_uart_tx #(.CLK_DIV(4), .SYNC_BYTE(8'hA5), .FIFO_AW(2), .DECIM(1)) u_dut (
      .MCLK(mclk), .RST(rst), .data_trans(data_trans), .data_valid(data_valid),
      .TXD(txd1), .tx_busy(busy1), .frame_drop(drop1));

   i2s_frame_uart_tx #(.CLK_DIV(4), .SYNC_BYTE(8'hA5), .FIFO_AW(2), .DECIM(3)) u_dec (
      .MCLK(mclk), .RST(rst), .data_trans(data_trans), .data_valid(data_valid),
      .TXD(txd2), .tx_busy(busy2), .frame_drop(drop2));

   function automatic logic txd_of(input bit sel);
      return sel ? txd2 : txd1;
   endfunction

   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge mclk);
   endtask

   task automatic do_reset();
      @(negedge mclk);
      data_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge mclk);
      rst = 1'b0;
   endtask

   // Returns at the negedge of the cycle after capture (j+3); j = cycle valid dropped.
   task automatic send_word(input logic [63:0] w, output int j);
      data_trans = w;
      data_valid = 1'b1;
      repeat (2) @(negedge mclk);
      data_valid = 1'b0;
      j = cyc;
      repeat (3) @(negedge mclk);
   endtask

   task automatic wait_start(input bit sel, input int maxc, output int s);
      int n = 0;
      while (txd_of(sel) !== 1'b0 && n < maxc) begin
         @(negedge mclk);
         n++;
      end
      s = (txd_of(sel) === 1'b0) ? cyc : -1;
   endtask

   // Starts at the first cycle of the sync start bit, ends on the last stop bit's first cycle.
   task automatic recv_frame(input bit sel, output logic [71:0] fr, output int bad);
      fr  = '0;
      bad = 0;
      for (int b = 0; b < 9; b++) begin
         if (txd_of(sel) !== 1'b0) bad++;
         for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge mclk);
            fr[(8-b)*8+i] = txd_of(sel);
         end
         repeat (4) @(negedge mclk);
         if (txd_of(sel) !== 1'b1) bad++;
         if (b < 8) repeat (4) @(negedge mclk);
      end
   endtask

   // From stop cycle 0: 3 more stop cycles, IDLE, LOAD high, then start bit.
   task automatic gap(input bit sel, output bit ok);
      ok = 1'b1;
      repeat (5) begin
         @(negedge mclk);
         if (txd_of(sel) !== 1'b1) ok = 1'b0;
      end
      @(negedge mclk);
      if (txd_of(sel) !== 1'b0) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      data_valid = 1'b0;
      repeat (3) @(negedge mclk);
      tests++;
      if ({txd1, busy1, drop1} !== {1'b1, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_state: txd=%b busy=%b drop=%h want 1 0 00", txd1, busy1, drop1);
      end
      rst = 1'b0;
      repeat (20) @(negedge mclk);
      tests++;
      if ({txd1, busy1, drop1} !== {1'b1, 1'b0, 8'h00}) begin
         fails++;
         $display("FAIL reset_idle: txd=%b busy=%b drop=%h want 1 0 00", txd1, busy1, drop1);
      end
   endtask

   task automatic test_single();
      int j, bad;
      logic [71:0] fr;
      bit pre, fall;
      do_reset();
      send_word(64'h01123456_00ABCDEF, j);
      to_cyc(j + 4);
      pre = (txd1 === 1'b1);
      @(negedge mclk);
      fall = (txd1 === 1'b0);
      tests++;
      if (!(pre && fall)) begin
         fails++;
         $display("FAIL start_latency: txd high@+4=%b low@+5=%b want 1 1", pre, fall);
      end
      recv_frame(1'b0, fr, bad);
      tests++;
      if (fr !== 72'hA5_01123456_00ABCDEF || bad != 0) begin
         fails++;
         $display("FAIL single_frame: got %h framing_err=%0d want a50112345600abcdef 0", fr, bad);
      end
      tests++;
      if (busy1 !== 1'b1) begin
         fails++;
         $display("FAIL busy_in_frame: got %b want 1", busy1);
      end
      repeat (10) @(negedge mclk);
      tests++;
      if (busy1 !== 1'b0 || txd1 !== 1'b1) begin
         fails++;
         $display("FAIL busy_drop: busy=%b txd=%b want 0 1", busy1, txd1);
      end
   endtask

   task automatic test_burst();
      logic [63:0] w [6];
      logic [71:0] fr;
      int j, s, bad;
      bit ok;
      for (int k = 0; k < 6; k++) w[k] = 64'(k + 1) * 64'h1111_0000_2222_0003;
      do_reset();
      send_word(w[0], j);
      wait_start(1'b0, 20, s);
      tests++;
      if (s != j + 5) begin
         fails++;
         $display("FAIL burst_first_start: cycle %0d want %0d", s, j + 5);
      end
      for (int k = 1; k < 6; k++) send_word(w[k], j);
      tests++;
      if (drop1 !== 8'd1) begin
         fails++;
         $display("FAIL burst_drop: got %0d want 1", drop1);
      end
      to_cyc(s + 356);
      for (int k = 1; k < 5; k++) begin
         gap(1'b0, ok);
         recv_frame(1'b0, fr, bad);
         tests++;
         if (!ok || bad != 0 || fr !== {8'hA5, w[k]}) begin
            fails++;
            $display("FAIL burst_frame%0d: got %h gap_ok=%b err=%0d want %h", k, fr, ok, bad,
                     {8'hA5, w[k]});
         end
      end
      repeat (10) @(negedge mclk);
      wait_start(1'b0, 400, s);
      tests++;
      if (s != -1 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL burst_sixth_sent: start=%0d busy=%b want -1 0", s, busy1);
      end
   endtask

   task automatic test_pop_full();
      logic [63:0] w [6];
      logic [71:0] fr;
      int j, s, bad;
      bit ok;
      for (int k = 0; k < 6; k++) w[k] = 64'hF0E1D2C3_B4A59687 ^ (64'(k) << 8);
      do_reset();
      send_word(w[0], j);
      wait_start(1'b0, 20, s);
      for (int k = 1; k < 5; k++) send_word(w[k], j);
      to_cyc(s + 356);
      data_trans = w[5];
      data_valid = 1'b1;
      to_cyc(s + 359);
      data_valid = 1'b0;
      to_cyc(s + 362);
      tests++;
      if (drop1 !== 8'd0 || txd1 !== 1'b0) begin
         fails++;
         $display("FAIL popfull_accept: drop=%0d txd=%b want 0 0", drop1, txd1);
      end
      for (int k = 1; k < 6; k++) begin
         recv_frame(1'b0, fr, bad);
         tests++;
         if (bad != 0 || fr !== {8'hA5, w[k]}) begin
            fails++;
            $display("FAIL popfull_frame%0d: got %h err=%0d want %h", k, fr, bad, {8'hA5, w[k]});
         end
         if (k < 5) begin
            gap(1'b0, ok);
            tests++;
            if (!ok) begin
               fails++;
               $display("FAIL popfull_gap%0d: got bad gap want 2 idle cycles", k);
            end
         end
      end
   endtask

   task automatic test_decim();
      logic [63:0] w [10];
      logic [71:0] fr [3];
      int bad [3];
      bit ok [2];
      int s;
      for (int k = 1; k < 10; k++) w[k] = 64'(k) * 64'h0101_0101_0101_0101;
      do_reset();
      fork
         begin
            int j;
            for (int k = 1; k < 10; k++) send_word(w[k], j);
         end
         begin
            wait_start(1'b1, 100, s);
            recv_frame(1'b1, fr[0], bad[0]);
            gap(1'b1, ok[0]);
            recv_frame(1'b1, fr[1], bad[1]);
            gap(1'b1, ok[1]);
            recv_frame(1'b1, fr[2], bad[2]);
         end
      join
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (bad[k] != 0 || fr[k] !== {8'hA5, w[3*k+1]}) begin
            fails++;
            $display("FAIL decim_frame%0d: got %h err=%0d want %h", k, fr[k], bad[k],
                     {8'hA5, w[3*k+1]});
         end
      end
      repeat (10) @(negedge mclk);
      wait_start(1'b1, 400, s);
      tests++;
      if (s != -1 || drop2 !== 8'd0 || !ok[0] || !ok[1]) begin
         fails++;
         $display("FAIL decim_extra: start=%0d drop=%0d gaps=%b%b want -1 0 11", s, drop2,
                  ok[0], ok[1]);
      end
   endtask

   task automatic test_mid_reset();
      logic [71:0] fr;
      int j, s, bad;
      bit low_before;
      do_reset();
      send_word(64'h11223300_44556677, j);
      wait_start(1'b0, 20, s);
      send_word(64'hDEADBEEF_CAFEF00D, j);
      to_cyc(s + 172);
      low_before = (txd1 === 1'b0);
      rst = 1'b1;
      @(negedge mclk);
      tests++;
      if (!low_before || txd1 !== 1'b1 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL midrst_txd: low_before=%b txd=%b busy=%b want 1 1 0", low_before,
                  txd1, busy1);
      end
      repeat (2) @(negedge mclk);
      rst = 1'b0;
      wait_start(1'b0, 400, s);
      tests++;
      if (s != -1 || drop1 !== 8'd0) begin
         fails++;
         $display("FAIL midrst_fifo_clear: start=%0d drop=%0d want -1 0", s, drop1);
      end
      send_word(64'h0A0B0C0D_0E0F1011, j);
      wait_start(1'b0, 20, s);
      recv_frame(1'b0, fr, bad);
      tests++;
      if (bad != 0 || fr !== 72'hA5_0A0B0C0D_0E0F1011) begin
         fails++;
         $display("FAIL midrst_new_frame: got %h err=%0d want a50a0b0c0d0e0f1011", fr, bad);
      end
   endtask

   task automatic test_saturate();
      int j;
      bit wrapped = 1'b0;
      logic [7:0] prev = 8'd0;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         send_word(64'(k) * 64'h0001_0003_0005_0007, j);
         if (drop1 < prev) wrapped = 1'b1;
         prev = drop1;
      end
      tests++;
      if (drop1 !== 8'hFF || wrapped) begin
         fails++;
         $display("FAIL drop_saturate: got %h wrapped=%b want ff 0", drop1, wrapped);
      end
      do_reset();
      tests++;
      if (drop1 !== 8'h00) begin
         fails++;
         $display("FAIL drop_reset: got %h want 00", drop1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_pop_full();
      test_decim();
      test_mid_reset();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
